crc_sched: RTL and testbench
============================

CRC_SCHED -- requirements
Module: crc_sched

Interface
REQ-001 Parameter DATA_W, default 10: payload bits per request.
REQ-002 Parameter CRC_W, default 5: CRC width.
REQ-003 Parameter POLY, default 5'b00101: CRC-5 generator x^5+x^2+1, MSB-first, no reflection, init 0, no final XOR.
REQ-004 Port clk, input, 1: single clock; all state on rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port req, input, 2: level request from requester 0/1.
REQ-007 Port data0, input, DATA_W: payload of requester 0.
REQ-008 Port data1, input, DATA_W: payload of requester 1.
REQ-009 Port gnt, output, 2: one-cycle registered pulse; payload of that requester captured.
REQ-010 Port busy, output, 1: high in any state other than IDLE.
REQ-011 Port out_valid, output, 1: codeword available.
REQ-012 Port out_id, output, 1: requester index owning the codeword.
REQ-013 Port data_out, output, DATA_W+CRC_W: {payload, crc}.
REQ-014 Port out_ready, input, 1: consumer accepts codeword when high with out_valid.

Function
REQ-015 The FSM SHALL have states IDLE, SHIFT and OUT.
REQ-016 In IDLE with req != 0, the next edge SHALL latch the winner's payload, assert its gnt bit for exactly one cycle, clear the bit counter and CRC register, and enter SHIFT.
REQ-017 Arbitration SHALL be round-robin: with both requests high, the requester not granted last wins; after reset requester 0 has priority.
REQ-018 A single active request SHALL win regardless of the pointer; the pointer SHALL update only on a grant.
REQ-019 SHIFT SHALL process one payload bit per cycle, MSB first: fb = crc[CRC_W-1] ^ bit; crc = {crc[CRC_W-2:0],0} ^ (fb ? POLY : 0).
REQ-020 After exactly DATA_W SHIFT cycles the FSM SHALL enter OUT with out_valid=1, data_out={payload,crc}, out_id=winner; out_valid rises DATA_W+1 edges after the capture edge.
REQ-021 In OUT, out_valid, data_out and out_id SHALL hold stable until an edge with out_ready=1, after which out_valid=0 and FSM=IDLE.
REQ-022 A new grant SHALL NOT occur in the same cycle as an OUT handshake; earliest next gnt is one cycle after return to IDLE.
REQ-023 req is level-sensitive: a requester still asserting req after its gnt SHALL be treated as a new request.
REQ-024 Requests dropped before grant SHALL have no effect; req, data0/1 changes outside the IDLE capture edge SHALL not affect the codeword in progress.
REQ-025 out_ready while not in OUT SHALL be ignored.
REQ-026 data_out SHALL be zero outside OUT.

Reset
REQ-027 rst high SHALL immediately force FSM=IDLE, gnt=0, busy=0, out_valid=0, out_id=0, data_out=0, counter=0, CRC=0, RR pointer to favour requester 0.
REQ-028 Reset in SHIFT or OUT SHALL abort the operation with no codeword emitted; operation resumes on the first edge after rst falls.

Structure
REQ-029 A shared package crc_pkg SHALL hold DATA_W, CRC_W, POLY and the FSM state enum.
REQ-030 The bit-serial CRC register SHALL be a sub-module crc5_serial (ports: clk, rst, clr, en, bit_in, crc); arbitration, FSM and output register stay in crc_sched.

Verification
REQ-031 req=01, data0=10'b1010001101, out_ready=1 -> gnt=01 one cycle; out_valid 11 edges after capture; data_out=15'b1010001101_01111, out_id=0.
REQ-032 req=11 held, data0=10'h000, data1=10'h3FF, out_ready=1 -> grants alternate 01,10,01,...; data0 codeword 15'h0000, out_id toggles each result.
REQ-033 Single request, out_ready=0 for 5 cycles in OUT -> out_valid and data_out stable 5 cycles; accepted on first out_ready=1; busy falls next cycle.
REQ-034 rst pulse during SHIFT bit 4 -> all outputs 0 asynchronously; no out_valid; next req=10 grants requester 1 and yields correct CRC.
REQ-035 req=00 for 20 cycles, out_ready toggling -> gnt, busy, out_valid stay 0.

Source files
------------

// File: rtl/crc_pkg.sv
// crc_pkg: shared CRC-5 scheduler constants and FSM state encoding
package crc_pkg;
  localparam int DATA_W = 10;
  localparam int CRC_W = 5;
  localparam logic [CRC_W-1:0] POLY = 5'b00101;
  typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;
endpackage

// File: rtl/crc5_serial.sv
// crc5_serial: bit-serial MSB-first CRC register (clk, rst async, clr, en, bit_in -> crc)
module crc5_serial #(
  parameter int CRC_W = crc_pkg::CRC_W,
  parameter logic [CRC_W-1:0] POLY = crc_pkg::POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);
  logic fb;
  assign fb = crc[CRC_W-1] ^ bit_in;
  always_ff @(posedge clk or posedge rst)
    if (rst) crc <= '0;
    else if (clr) crc <= '0;
    else if (en) crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
endmodule

// File: rtl/crc_sched.sv
// crc_sched: round-robin 2-requester arbiter feeding a bit-serial CRC-5 codeword generator
// ports: clk, rst (async), req[1:0], data0/data1 payloads -> gnt pulse, busy,
//        out_valid/out_id/data_out {payload,crc} with out_ready handshake
module crc_sched #(
  parameter int DATA_W = crc_pkg::DATA_W,
  parameter int CRC_W = crc_pkg::CRC_W,
  parameter logic [CRC_W-1:0] POLY = crc_pkg::POLY
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req,
  input  logic [DATA_W-1:0]       data0,
  input  logic [DATA_W-1:0]       data1,
  output logic [1:0]              gnt,
  output logic                    busy,
  output logic                    out_valid,
  output logic                    out_id,
  output logic [DATA_W+CRC_W-1:0] data_out,
  input  logic                    out_ready
);
  import crc_pkg::*;
  localparam int CNT_W = $clog2(DATA_W + 1);
  state_t state, nxt;
  logic [DATA_W-1:0] payload, sh;
  logic [CNT_W-1:0] cnt;
  logic [CRC_W-1:0] crc;
  logic ptr, id, win, take, done, acc;
  // ptr holds the last winner; reset to 1 so requester 0 is favoured first
  assign win = &req ? ~ptr : req[1];
  assign take = state == IDLE && |req;
  // cnt reaches DATA_W one cycle after the last bit, so the CRC is final when OUT loads
  assign done = state == SHIFT && cnt == CNT_W'(DATA_W);
  assign acc = state == OUT && out_ready;
  assign busy = state != IDLE;
  crc5_serial #(.CRC_W(CRC_W), .POLY(POLY)) u_crc (
    .clk(clk),
    .rst(rst),
    .clr(take),
    .en(state == SHIFT && !done),
    .bit_in(sh[DATA_W-1]),
    .crc(crc)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    nxt = take ? SHIFT : done ? OUT : acc ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      gnt <= '0;
      ptr <= 1'b1;
      id <= 1'b0;
      payload <= '0;
      sh <= '0;
      cnt <= '0;
      out_valid <= 1'b0;
      out_id <= 1'b0;
      data_out <= '0;
    end else begin
      gnt <= take ? (win ? 2'b10 : 2'b01) : 2'b00;
      if (take) begin
        ptr <= win;
        id <= win;
        payload <= win ? data1 : data0;
        sh <= win ? data1 : data0;
        cnt <= '0;
      end else if (state == SHIFT && !done) begin
        sh <= {sh[DATA_W-2:0], 1'b0};
        cnt <= cnt + 1'b1;
      end
      if (done) begin
        out_valid <= 1'b1;
        out_id <= id;
        data_out <= {payload, crc};
      end else if (acc) begin
        out_valid <= 1'b0;
        out_id <= 1'b0;
        data_out <= '0;
      end
    end
endmodule

// File: tb/tb_crc_sched.sv
// tb_crc_sched: scoreboard bench for crc_sched with directed, hand-computed CRC-5 vectors
module tb_crc_sched;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] req = '0;
  logic [9:0] data0 = '0;
  logic [9:0] data1 = '0;
  logic out_ready = 1'b0;
  logic [1:0] gnt;
  logic busy, out_valid, out_id;
  logic [14:0] data_out;
  int errors = 0;
  int checks = 0;
  int hs = 0;
  logic [15:0] cq[$];
  logic [1:0] gq[$];

  crc_sched dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .data0(data0),
    .data1(data1),
    .gnt(gnt),
    .busy(busy),
    .out_valid(out_valid),
    .out_id(out_id),
    .data_out(data_out),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected nothing", nm, act);
  endtask

  always @(negedge clk)
    if (!rst) begin
      if (gnt != 2'b00) begin
        if (gq.size() == 0) fail_now("unexpected_gnt", 32'(gnt));
        else chk("gnt", 32'(gnt), 32'(gq.pop_front()));
      end
      if (out_valid && out_ready) begin
        hs++;
        if (cq.size() == 0) fail_now("unexpected_out", 32'({out_id, data_out}));
        else chk("codeword", 32'({out_id, data_out}), 32'(cq.pop_front()));
      end
      if (!out_valid) chk("data_out_zero", 32'(data_out), 0);
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy || cq.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    chk({nm, "_idle_timeout"}, 32'(n < 200), 1);
  endtask

  task automatic wait_valid(input string nm, input int exp_lat);
    int n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'(exp_lat));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hs0;
    #1 rst = 1'b1;
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_id", 32'(out_id), 0);
    chk("rst_data_out", 32'(data_out), 0);
    tick();
    rst = 1'b0;
    // single request from requester 0
    out_ready = 1'b1;
    data0 = 10'b1010001101;
    req = 2'b01;
    gq.push_back(2'b01);
    cq.push_back({1'b0, 15'h51AF});
    tick();
    req = 2'b00;
    data0 = 10'h155;
    chk("t1_busy", 32'(busy), 1);
    wait_valid("t1", 11);
    chk("t1_out_id", 32'(out_id), 0);
    wait_idle("t1");
    // both requesters held: grants alternate starting with 0 after reset
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    data0 = 10'h000;
    data1 = 10'h3FF;
    for (int i = 0; i < 2; i++) begin
      gq.push_back(2'b01);
      gq.push_back(2'b10);
      cq.push_back({1'b0, 15'h0000});
      cq.push_back({1'b1, 15'h7FF5});
    end
    hs0 = hs;
    req = 2'b11;
    begin
      int n = 0;
      while (hs < hs0 + 4 && n < 200) begin
        tick();
        n++;
      end
      chk("t2_timeout", 32'(n < 200), 1);
    end
    req = 2'b00;
    wait_idle("t2");
    // back-pressure: codeword must hold while out_ready is low
    out_ready = 1'b0;
    data0 = 10'h200;
    req = 2'b01;
    gq.push_back(2'b01);
    cq.push_back({1'b0, 15'h401D});
    tick();
    req = 2'b00;
    wait_valid("t3", 11);
    repeat (5) begin
      tick();
      chk("t3_hold_valid", 32'(out_valid), 1);
      chk("t3_hold_data", 32'(data_out), 32'h401D);
    end
    out_ready = 1'b1;
    tick();
    chk("t3_busy_after", 32'(busy), 0);
    chk("t3_valid_after", 32'(out_valid), 0);
    // reset during SHIFT aborts; requester 1 then served correctly
    data0 = 10'h3FF;
    req = 2'b01;
    gq.push_back(2'b01);
    tick();
    req = 2'b00;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t4_rst_busy", 32'(busy), 0);
    chk("t4_rst_out", 32'({gnt, out_valid, out_id}), 0);
    chk("t4_rst_data", 32'(data_out), 0);
    tick();
    rst = 1'b0;
    data1 = 10'h001;
    req = 2'b10;
    gq.push_back(2'b10);
    cq.push_back({1'b1, 15'h0025});
    tick();
    req = 2'b00;
    wait_valid("t4", 11);
    wait_idle("t4");
    // no requests: everything stays quiet regardless of out_ready
    for (int i = 0; i < 20; i++) begin
      tick();
      out_ready = ~out_ready;
      chk("t5_quiet", 32'({gnt, busy, out_valid}), 0);
    end
    chk("gq_empty", 32'(gq.size()), 0);
    chk("cq_empty", 32'(cq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
